// File: rtl/otter_arb_pkg.sv
// otter_arb_pkg: shared owner tags and constants for the memory arbiter
package otter_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int LAT_MAX = 4;
endpackage

// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: requester and memory-side signals of the arbiter; slave = arbiter, master = surrounding system
interface otter_mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_GNT;
  logic              IF_RVALID;
  logic [31:0]       IF_RDATA;
  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic [1:0]        D_SIZE;
  logic              D_SIGN;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic              MEM_WE;
  logic [31:0]       MEM_WDATA;
  logic [1:0]        MEM_SIZE;
  logic              MEM_SIGN;
  logic [31:0]       MEM_RDATA;
  modport slave (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN, MEM_RDATA,
    output IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
           MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, MEM_SIZE, MEM_SIGN
  );
  modport master (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN, MEM_RDATA,
    input  IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
           MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, MEM_SIZE, MEM_SIGN
  );
endinterface

// File: rtl/otter_arb_tag_pipe.sv
// otter_arb_tag_pipe: LAT-deep shift register of read owners, cleared synchronously
module otter_arb_tag_pipe
  import otter_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e tag_in,
  output owner_e tag_out
);
  owner_e tags_q [LAT];
  owner_e tags_d [LAT];
  // shift one stage per cycle, new owner enters at stage 0
  always_comb begin
    tags_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) tags_d[i] = tags_q[i-1];
  end
  // reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) tags_q <= '{default: OWN_NONE};
    else tags_q <= tags_d;
  end
  assign tag_out = tags_q[LAT-1];
endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares the OTTER memory port between fetch and load/store; OTTER_ARB_PERF_CNT_EN adds stall/conflict counters
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int RR_EN  = 1,
  parameter int ADDR_W = 32
) (
  input logic CLK,
  input logic RST,
  otter_mem_arbiter_if.slave bus
`ifdef OTTER_ARB_PERF_CNT_EN
  ,
  output logic [31:0] IF_STALL_CNT,
  output logic [31:0] D_STALL_CNT,
  output logic [31:0] CONFLICT_CNT
`endif
);
  logic   both, d_pref, gnt_if, gnt_d, ptr_q, ptr_d, if_rv, d_rv;
  owner_e tag_in, tag_out;
  if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_chk
    $error("otter_mem_arbiter: LAT out of range");
  end
  // grant, memory drive and response routing; ptr_q=1 means D preferred
  always_comb begin
    both          = bus.IF_REQ & bus.D_REQ;
    d_pref        = (RR_EN == 0) | ptr_q;
    gnt_d         = ~RST & bus.D_REQ & (~bus.IF_REQ | d_pref);
    gnt_if        = ~RST & bus.IF_REQ & ~(bus.D_REQ & d_pref);
    ptr_d         = (both & (gnt_if | gnt_d)) ? gnt_if : ptr_q;
    tag_in        = gnt_if ? OWN_IF : (gnt_d & ~bus.D_WE) ? OWN_D : OWN_NONE;
    bus.IF_GNT    = gnt_if;
    bus.D_GNT     = gnt_d;
    bus.MEM_ADDR  = gnt_d ? bus.D_ADDR : gnt_if ? bus.IF_ADDR : {ADDR_W{1'b0}};
    bus.MEM_RE    = gnt_if | (gnt_d & ~bus.D_WE);
    bus.MEM_WE    = gnt_d & bus.D_WE;
    bus.MEM_WDATA = gnt_d ? bus.D_WDATA : 32'h0;
    bus.MEM_SIZE  = gnt_d ? bus.D_SIZE : gnt_if ? MEM_SIZE_WORD : 2'b00;
    bus.MEM_SIGN  = gnt_d & bus.D_SIGN;
    if_rv         = ~RST & (tag_out == OWN_IF);
    d_rv          = ~RST & (tag_out == OWN_D);
    bus.IF_RVALID = if_rv;
    bus.D_RVALID  = d_rv;
    bus.IF_RDATA  = if_rv ? bus.MEM_RDATA : 32'h0;
    bus.D_RDATA   = d_rv ? bus.MEM_RDATA : 32'h0;
  end
  // round-robin pointer, IF preferred out of reset
  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
  otter_arb_tag_pipe #(.LAT(LAT)) u_tags (
    .clk    (CLK),
    .rst    (RST),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );
`ifdef OTTER_ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt_q, if_stall_cnt_d, d_stall_cnt_q, d_stall_cnt_d, conflict_cnt_q, conflict_cnt_d;
  // count waiting and contended cycles, wrapping naturally
  always_comb begin
    if_stall_cnt_d = if_stall_cnt_q + 32'(bus.IF_REQ & ~gnt_if);
    d_stall_cnt_d  = d_stall_cnt_q + 32'(bus.D_REQ & ~gnt_d);
    conflict_cnt_d = conflict_cnt_q + 32'(both);
  end
  // counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_stall_cnt_q <= '0;
      d_stall_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if_stall_cnt_q <= if_stall_cnt_d;
      d_stall_cnt_q  <= d_stall_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end
  assign IF_STALL_CNT = if_stall_cnt_q;
  assign D_STALL_CNT  = d_stall_cnt_q;
  assign CONFLICT_CNT = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: scoreboard bench for a round-robin LAT=1 arbiter and a fixed-priority LAT=3 arbiter
module tb_otter_mem_arbiter;
  import otter_arb_pkg::*;
  typedef struct {
    owner_e      own;
    logic [31:0] data;
    int          due;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  rsp_t qa[$];
  rsp_t qb[$];
  rsp_t ea, eb;
  logic [31:0] a_rd;
  logic [31:0] b_rd [3];
  otter_mem_arbiter_if #(.ADDR_W(32)) a_bus ();
  otter_mem_arbiter_if #(.ADDR_W(32)) b_bus ();
`ifdef OTTER_ARB_PERF_CNT_EN
  logic [31:0] a_ifs, a_ds, a_cf, b_ifs, b_ds, b_cf;
`endif
  otter_mem_arbiter #(.LAT(1), .RR_EN(1), .ADDR_W(32)) dut_a (
    .CLK(clk), .RST(rst), .bus(a_bus)
`ifdef OTTER_ARB_PERF_CNT_EN
    , .IF_STALL_CNT(a_ifs), .D_STALL_CNT(a_ds), .CONFLICT_CNT(a_cf)
`endif
  );
  otter_mem_arbiter #(.LAT(3), .RR_EN(0), .ADDR_W(32)) dut_b (
    .CLK(clk), .RST(rst), .bus(b_bus)
`ifdef OTTER_ARB_PERF_CNT_EN
    , .IF_STALL_CNT(b_ifs), .D_STALL_CNT(b_ds), .CONFLICT_CNT(b_cf)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memval(input logic [31:0] ad);
    case (ad)
      32'h0:    return 32'h13;
      32'h4:    return 32'h93;
      32'h8:    return 32'h113;
      32'h6000: return 32'hDEADBEEF;
      default:  return ad ^ 32'h5A5A0000;
    endcase
  endfunction
  // memory models: read data follows the granted address by the arbiter latency
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    a_rd    <= a_bus.MEM_ADDR;
    b_rd[0] <= b_bus.MEM_ADDR;
    b_rd[1] <= b_rd[0];
    b_rd[2] <= b_rd[1];
  end
  assign a_bus.MEM_RDATA = memval(a_rd);
  assign b_bus.MEM_RDATA = memval(b_rd[2]);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input bit on_b, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] wdata, input logic [1:0] sz, input logic sg,
                      input logic eig, input logic edg, input logic [31:0] erd, input string nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (on_b) begin
      b_bus.IF_REQ = ireq; b_bus.IF_ADDR = iaddr; b_bus.D_REQ = dreq; b_bus.D_WE = dwe;
      b_bus.D_ADDR = daddr; b_bus.D_WDATA = wdata; b_bus.D_SIZE = sz; b_bus.D_SIGN = sg;
    end else begin
      a_bus.IF_REQ = ireq; a_bus.IF_ADDR = iaddr; a_bus.D_REQ = dreq; a_bus.D_WE = dwe;
      a_bus.D_ADDR = daddr; a_bus.D_WDATA = wdata; a_bus.D_SIZE = sz; a_bus.D_SIGN = sg;
    end
    @(negedge clk);
    chk({nm, "_if_gnt"}, on_b ? b_bus.IF_GNT : a_bus.IF_GNT, eig);
    chk({nm, "_d_gnt"}, on_b ? b_bus.D_GNT : a_bus.D_GNT, edg);
    if (eig | (edg & ~dwe)) begin
      if (on_b) qb.push_back('{eig ? OWN_IF : OWN_D, erd, cyc + 3});
      else qa.push_back('{eig ? OWN_IF : OWN_D, erd, cyc + 1});
    end
  endtask
  // response monitors: every RVALID must match the oldest outstanding read
  always @(negedge clk) begin
    if (a_bus.IF_RVALID | a_bus.D_RVALID) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexp_rsp: if_rvalid=%b d_rvalid=%b with no read outstanding", a_bus.IF_RVALID, a_bus.D_RVALID);
      end else begin
        ea = qa.pop_front();
        chk("a_rsp_owner", {30'd0, a_bus.D_RVALID, a_bus.IF_RVALID}, ea.own == OWN_IF ? 32'd1 : 32'd2);
        chk("a_rsp_data", a_bus.IF_RVALID ? a_bus.IF_RDATA : a_bus.D_RDATA, ea.data);
        chk("a_rsp_cycle", cyc, ea.due);
      end
    end
    if (!a_bus.IF_RVALID) chk("a_if_rdata_idle", a_bus.IF_RDATA, 32'h0);
    if (!a_bus.D_RVALID) chk("a_d_rdata_idle", a_bus.D_RDATA, 32'h0);
  end
  always @(negedge clk) begin
    if (b_bus.IF_RVALID | b_bus.D_RVALID) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexp_rsp: if_rvalid=%b d_rvalid=%b with no read outstanding", b_bus.IF_RVALID, b_bus.D_RVALID);
      end else begin
        eb = qb.pop_front();
        chk("b_rsp_owner", {30'd0, b_bus.D_RVALID, b_bus.IF_RVALID}, eb.own == OWN_IF ? 32'd1 : 32'd2);
        chk("b_rsp_data", b_bus.IF_RVALID ? b_bus.IF_RDATA : b_bus.D_RDATA, eb.data);
        chk("b_rsp_cycle", cyc, eb.due);
      end
    end
    if (!b_bus.IF_RVALID) chk("b_if_rdata_idle", b_bus.IF_RDATA, 32'h0);
    if (!b_bus.D_RVALID) chk("b_d_rdata_idle", b_bus.D_RDATA, 32'h0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    a_bus.IF_REQ = 1; a_bus.IF_ADDR = 0; a_bus.D_REQ = 1; a_bus.D_WE = 0;
    a_bus.D_ADDR = 32'h6000; a_bus.D_WDATA = 0; a_bus.D_SIZE = 2'b10; a_bus.D_SIGN = 0;
    b_bus.IF_REQ = 1; b_bus.IF_ADDR = 0; b_bus.D_REQ = 1; b_bus.D_WE = 0;
    b_bus.D_ADDR = 32'h6000; b_bus.D_WDATA = 0; b_bus.D_SIZE = 2'b10; b_bus.D_SIGN = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_if_gnt", a_bus.IF_GNT, 0);
      chk("rst_a_d_gnt", a_bus.D_GNT, 0);
      chk("rst_a_mem_re", a_bus.MEM_RE, 0);
      chk("rst_b_if_gnt", b_bus.IF_GNT, 0);
      chk("rst_b_d_gnt", b_bus.D_GNT, 0);
      chk("rst_a_rvalid", {a_bus.IF_RVALID, a_bus.D_RVALID}, 0);
    end
    b_bus.IF_REQ = 0; b_bus.D_REQ = 0;
    step(0, 1, 32'h0, 1, 0, 32'h6000, 0, 2'b10, 0, 1, 0, 32'h13,       "rr1");
    step(0, 1, 32'h4, 1, 0, 32'h6000, 0, 2'b10, 0, 0, 1, 32'hDEADBEEF, "rr2");
    step(0, 1, 32'h4, 1, 0, 32'h6004, 0, 2'b10, 0, 1, 0, 32'h93,       "rr3");
    step(0, 1, 32'h8, 1, 0, 32'h6004, 0, 2'b10, 0, 0, 1, 32'h5A5A6004, "rr4");
    step(0, 1, 32'h8, 0, 0, 32'h0,    0, 2'b00, 0, 1, 0, 32'h113,      "if1");
    step(0, 1, 32'h0, 0, 0, 32'h0,    0, 2'b00, 0, 1, 0, 32'h13,       "if2");
    chk("if2_mem_re", a_bus.MEM_RE, 1);
    chk("if2_mem_we", a_bus.MEM_WE, 0);
    chk("if2_mem_size", a_bus.MEM_SIZE, 2'b10);
    chk("if2_mem_addr", a_bus.MEM_ADDR, 32'h0);
    step(0, 1, 32'h4, 0, 0, 32'h0,    0, 2'b00, 0, 1, 0, 32'h93,       "if3");
    step(0, 1, 32'h8, 0, 0, 32'h0,    0, 2'b00, 0, 1, 0, 32'h113,      "if4");
    step(0, 0, 32'h0, 1, 1, 32'h11000000, 32'hA5, 2'b00, 0, 0, 1, 32'h0, "st");
    chk("st_mem_we", a_bus.MEM_WE, 1);
    chk("st_mem_re", a_bus.MEM_RE, 0);
    chk("st_mem_addr", a_bus.MEM_ADDR, 32'h11000000);
    chk("st_mem_wdata", a_bus.MEM_WDATA, 32'hA5);
    chk("st_mem_size", a_bus.MEM_SIZE, 2'b00);
    step(0, 1, 32'hC,  0, 0, 32'h0,    0, 2'b00, 0, 1, 0, 32'h5A5A000C, "if_after_st");
    step(0, 1, 32'h10, 1, 0, 32'h6000, 0, 2'b10, 0, 1, 0, 32'h5A5A0010, "rr_ptr_kept");
    step(0, 0, 32'h0,  0, 0, 32'h0,    0, 2'b00, 0, 0, 0, 32'h0, "idle_a");
    chk("idle_mem_re", a_bus.MEM_RE, 0);
    chk("idle_mem_addr", a_bus.MEM_ADDR, 32'h0);
    chk("idle_mem_size", a_bus.MEM_SIZE, 2'b00);
    step(0, 0, 32'h0,  0, 0, 32'h0,    0, 2'b00, 0, 0, 0, 32'h0, "idle_a2");
    chk("a_drained", qa.size(), 0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    repeat (4) step(1, 1, 32'h20, 1, 0, 32'h6000, 0, 2'b10, 0, 0, 1, 32'hDEADBEEF, "fp");
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 32'h0, "fp_idle");
`ifdef OTTER_ARB_PERF_CNT_EN
    chk("b_if_stall_cnt", b_ifs, 32'd4);
    chk("b_d_stall_cnt", b_ds, 32'd0);
    chk("b_conflict_cnt", b_cf, 32'd4);
`endif
    repeat (3) step(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 32'h0, "fp_drain");
    chk("b_drained", qb.size(), 0);
    step(1, 1, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, 1, 0, 32'h13,  "fl1");
    step(1, 1, 32'h4, 0, 0, 32'h0, 0, 2'b00, 0, 1, 0, 32'h93,  "fl2");
    step(1, 1, 32'h8, 0, 0, 32'h0, 0, 2'b00, 0, 1, 0, 32'h113, "fl3");
    @(posedge clk); #1; rst = 1'b1; b_bus.IF_REQ = 0; qb.delete();
    @(negedge clk);
    chk("b_rst_if_rvalid", b_bus.IF_RVALID, 0);
    chk("b_rst_if_gnt", b_bus.IF_GNT, 0);
    repeat (4) begin
      step(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 32'h0, "post_rst");
      chk("b_post_rst_if_rvalid", b_bus.IF_RVALID, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single data port of the OTTER byte-addressable memory between two requesters: instruction fetch (IF) and load/store (D).
- Used when fetch and data access are no longer sequenced by the multicycle FSM, i.e. for pipelined or prefetching cores.
- Grants at most one access per cycle.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes returning read data to the correct requester.

Parameters:
- LAT, 1, memory read latency in cycles, from grant edge to MEM_RDATA valid; legal range 1..4.
- RR_EN, 1, 1 = round-robin between IF and D; 0 = fixed priority, D over IF.
- ADDR_W, 32, address width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- IF_REQ  in  1  fetch request, held until granted.
- IF_ADDR  in  ADDR_W  fetch address, word aligned.
- IF_GNT  out  1  fetch accepted this cycle.
- IF_RVALID  out  1  IF_RDATA valid.
- IF_RDATA  out  32  fetched instruction.
- D_REQ  in  1  data request, held until granted.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  32  store data.
- D_SIZE  in  2  funct3[1:0] size code.
- D_SIGN  in  1  funct3[2], 1 = unsigned load.
- D_GNT  out  1  data access accepted this cycle.
- D_RVALID  out  1  load data valid.
- D_RDATA  out  32  load data.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_RE  out  1  memory read strobe.
- MEM_WE  out  1  memory write strobe.
- MEM_WDATA  out  32  memory write data.
- MEM_SIZE  out  2  access size to memory.
- MEM_SIGN  out  1  sign control to memory.
- MEM_RDATA  in  32  memory read data.

Behaviour:
- Grant logic is combinational from REQ, the round-robin pointer and RST.
  - IF_GNT and D_GNT are never both 1.
  - A requester with REQ=0 is never granted.
  - Both GNTs are 0 while RST=1.
- Memory drive follows the grant in the same cycle.
  - On a D grant: MEM_ADDR=D_ADDR, MEM_WE=D_WE, MEM_RE=~D_WE, and MEM_WDATA/SIZE/SIGN come from the D port.
  - On an IF grant: MEM_ADDR=IF_ADDR, MEM_RE=1, MEM_WE=0, MEM_SIZE=2'b10, MEM_SIGN=0.
  - With no grant: MEM_RE=MEM_WE=0; MEM_ADDR, MEM_WDATA, MEM_SIZE and MEM_SIGN are 0.
- Arbitration:
  - RR_EN=0: D wins whenever D_REQ=1.
  - RR_EN=1: a 1-bit pointer names the preferred requester. Reset value is IF preferred.
  - The pointer flips to the other requester only when a grant occurs while both requested. A lone requester is granted without moving the pointer.
- Tag pipeline: an LAT-deep shift register of owner tags (NONE/IF/D), shifted every cycle.
  - Stage 0 loads IF on an IF grant, D on a D-load grant, and NONE on a store or no grant.
  - When the tag at stage LAT-1 is IF, IF_RVALID=1 and IF_RDATA=MEM_RDATA in that cycle; the same rule applies to D.
  - RVALID is registered-tag driven, so response latency equals LAT exactly.
  - RDATA is 0 when the matching RVALID is 0.
- Stores produce no RVALID. A store is committed at the grant edge.
- Back-to-back grants every cycle are legal. Throughput is 1 access per cycle, with no bubble between requesters.
- Simultaneous response and new grant in the same cycle are independent.
- Reset mid-operation: all tags are cleared to NONE, in-flight reads are dropped, no RVALID is asserted after RST rises, and the pointer returns to IF.
- Reset values of registered outputs: IF_RVALID, D_RVALID, IF_RDATA and D_RDATA are all 0.

Optional Feature:
- Macro OTTER_ARB_PERF_CNT_EN.
- When defined, adds three outputs, each a 32-bit counter reset to 0 and wrapping at 2^32:
  - IF_STALL_CNT: cycles with IF_REQ=1 and IF_GNT=0.
  - D_STALL_CNT: cycles with D_REQ=1 and D_GNT=0.
  - CONFLICT_CNT: cycles with both REQ=1.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package otter_arb_pkg holds:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_IF, OWN_D};
  - constant MEM_SIZE_WORD = 2'b10;
  - constant LAT_MAX = 4.
- One sub-module, otter_arb_tag_pipe: the LAT-deep owner_e shift register with synchronous clear.

Test Plan:
- Reset with IF_REQ=D_REQ=1 held: both GNTs are 0 and no RVALID. After RST falls, first grant goes to IF (RR_EN=1).
- IF only at 0x0,0x4,0x8 on consecutive cycles, LAT=1, memory returns 0x13,0x93,0x113: IF_RVALID is high on 3 consecutive cycles, one cycle after each grant, with matching data in order.
- Both requesting continuously, RR_EN=1: grants alternate IF,D,IF,D; each requester gets its own data with no cross-routing (D load at 0x6000 returns 0xDEADBEEF to D_RDATA only).
- Same stimulus with RR_EN=0: D granted every cycle, IF_GNT stays 0. With the macro defined, IF_STALL_CNT=N after N cycles.
- D store at 0x11000000, WDATA 0xA5, SIZE 0: MEM_WE=1 and MEM_RE=0 in the grant cycle; no D_RVALID follows. An IF grant the next cycle returns normally.
- LAT=3 with three IF reads in flight, RST asserted for 1 cycle: no IF_RVALID appears in the following 3 cycles.
